// File: rtl/alarm_bank_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axusb_pkg : shared alarm state encoding and time limits           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package axusb_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} alarm_st_t;

   localparam logic [4:0] HOUR_MAX = 5'd23;
   localparam logic [5:0] MIN_MAX  = 6'd59;

endpackage
`default_nettype wire

// File: rtl/alarm_bank_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alarm_bank_if : keypad/timer side bus of the alarm bank           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface alarm_bank_if #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) ();
   logic            tick_1hz;
   logic [4:0]      cur_hour;
   logic [5:0]      cur_min;
   logic [5:0]      cur_sec;
   logic            wr_en;
   logic [CH_W-1:0] wr_ch;
   logic [4:0]      wr_hour;
   logic [5:0]      wr_min;
   logic            wr_arm;
   logic            ack;
   logic            snooze;
   logic            wr_err;
   logic [N_CH-1:0] armed;
   logic [N_CH-1:0] ring;
   logic            any_ring;
   logic            alarm_led;

   modport master (
      output tick_1hz, cur_hour, cur_min, cur_sec,
      output wr_en, wr_ch, wr_hour, wr_min, wr_arm, ack, snooze,
      input  wr_err, armed, ring, any_ring, alarm_led
   );

   modport slave (
      input  tick_1hz, cur_hour, cur_min, cur_sec,
      input  wr_en, wr_ch, wr_hour, wr_min, wr_arm, ack, snooze,
      output wr_err, armed, ring, any_ring, alarm_led
   );
endinterface
`default_nettype wire

// File: rtl/alarm_bank_chan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alarm_chan : one alarm channel - FSM, stored HH:MM, ring/snooze   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module alarm_chan
   import axusb_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr,
   input  logic [4:0] wr_hour,
   input  logic [5:0] wr_min,
   input  logic       wr_arm,
   input  logic       ack,
   input  logic       snooze,
   input  logic       tick,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic       armed,
   output logic       ring
);
   localparam int c_ring_w = $clog2(RING_SEC + 1);
   localparam int c_snz_w  = $clog2(SNOOZE_SEC + 1);

   localparam logic [c_ring_w-1:0] c_ring_load = c_ring_w'(RING_SEC);
   localparam logic [c_ring_w-1:0] c_ring_one  = c_ring_w'(1);
   localparam logic [c_snz_w-1:0]  c_snz_load  = c_snz_w'(SNOOZE_SEC);
   localparam logic [c_snz_w-1:0]  c_snz_one   = c_snz_w'(1);

   localparam logic [1:0] c_st_idle    = IDLE;
   localparam logic [1:0] c_st_armed   = ARMED;
   localparam logic [1:0] c_st_ringing = RINGING;
   localparam logic [1:0] c_st_snooze  = SNOOZE;

   logic [1:0]          r_state;
   logic [4:0]          r_hour;
   logic [5:0]          r_min;
   logic [c_ring_w-1:0] r_ring_cnt;
   logic [c_snz_w-1:0]  r_snz_cnt;
   logic                w_match;

   // Only second 0 can match, so a minute fires at most once.
   assign w_match = tick && (cur_sec == 6'd0) && (cur_hour == r_hour) && (cur_min == r_min);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_hour     <= '0;
         r_min      <= '0;
         r_ring_cnt <= '0;
         r_snz_cnt  <= '0;
      end else if (wr) begin
         r_hour     <= wr_hour;
         r_min      <= wr_min;
         r_state    <= wr_arm ? c_st_armed : c_st_idle;
         r_ring_cnt <= '0;
         r_snz_cnt  <= '0;
      end else if (ack && (r_state == c_st_ringing || r_state == c_st_snooze)) begin
         r_state    <= c_st_armed;
         r_ring_cnt <= '0;
         r_snz_cnt  <= '0;
      end else if (snooze && r_state == c_st_ringing) begin
         r_state    <= c_st_snooze;
         r_ring_cnt <= '0;
         r_snz_cnt  <= c_snz_load;
      end else if (tick) begin
         case (r_state)
            c_st_armed: begin
               if (w_match) begin
                  r_state    <= c_st_ringing;
                  r_ring_cnt <= c_ring_load;
               end
            end
            c_st_ringing: begin
               // Reaching zero on this tick ends the ring; the count never wraps.
               if (r_ring_cnt <= c_ring_one) begin
                  r_state    <= c_st_armed;
                  r_ring_cnt <= '0;
               end else begin
                  r_ring_cnt <= r_ring_cnt - c_ring_one;
               end
            end
            c_st_snooze: begin
               if (r_snz_cnt <= c_snz_one) begin
                  r_state    <= c_st_ringing;
                  r_snz_cnt  <= '0;
                  r_ring_cnt <= c_ring_load;
               end else begin
                  r_snz_cnt <= r_snz_cnt - c_snz_one;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign armed = (r_state != c_st_idle);
   assign ring  = (r_state == c_st_ringing);
endmodule
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alarm_bank : N-channel alarm engine with write decode and blink   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module alarm_bank
   import axusb_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int CH_W       = 2,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int BLINK_DIV  = 4000000
) (
   input  logic         mclk,
   input  logic         rst,
   alarm_bank_if.slave  bus
);
   localparam int c_presc_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(BLINK_DIV - 1);
   localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);
   localparam logic [CH_W:0]        c_n_ch      = (CH_W + 1)'(N_CH);

   logic                 w_wr_valid;
   logic [N_CH-1:0]      w_armed;
   logic [N_CH-1:0]      w_ring;
   logic                 w_any_ring;
   logic                 r_wr_err;
   logic                 r_phase;
   logic [c_presc_w-1:0] r_presc;

   assign w_wr_valid = bus.wr_en && (bus.wr_hour <= HOUR_MAX) && (bus.wr_min <= MIN_MAX)
                       && ({1'b0, bus.wr_ch} < c_n_ch);

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_chan
         alarm_chan #(
            .RING_SEC   (RING_SEC),
            .SNOOZE_SEC (SNOOZE_SEC)
         ) u_chan (
            .clk      (mclk),
            .rst      (rst),
            .wr       (w_wr_valid && (bus.wr_ch == CH_W'(i))),
            .wr_hour  (bus.wr_hour),
            .wr_min   (bus.wr_min),
            .wr_arm   (bus.wr_arm),
            .ack      (bus.ack),
            .snooze   (bus.snooze),
            .tick     (bus.tick_1hz),
            .cur_hour (bus.cur_hour),
            .cur_min  (bus.cur_min),
            .cur_sec  (bus.cur_sec),
            .armed    (w_armed[i]),
            .ring     (w_ring[i])
         );
      end
   endgenerate

   assign w_any_ring = |w_ring;

   always_ff @(posedge mclk) begin
      if (rst) begin
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= bus.wr_en && !w_wr_valid;
      end
   end

   // Held at zero while silent so every blink burst starts in the lit half.
   always_ff @(posedge mclk) begin
      if (rst || !w_any_ring) begin
         r_presc <= '0;
         r_phase <= 1'b0;
      end else if (r_presc == c_presc_max) begin
         r_presc <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_presc <= r_presc + c_presc_one;
      end
   end

   assign bus.wr_err    = r_wr_err;
   assign bus.armed     = w_armed;
   assign bus.ring      = w_ring;
   assign bus.any_ring  = w_any_ring;
   assign bus.alarm_led = w_any_ring & ~r_phase;
endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alarm_bank : directed scoreboard bench for alarm_bank          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_alarm_bank;
   localparam int N_CH       = 3;
   localparam int CH_W       = 2;
   localparam int RING_SEC   = 3;
   localparam int SNOOZE_SEC = 2;
   localparam int BLINK_DIV  = 4;

   typedef struct {
      int              cyc;
      string           name;
      logic [N_CH-1:0] armed;
      logic [N_CH-1:0] ring;
      logic            err;
      logic            led_chk;
      logic            led;
   } exp_t;

   logic mclk = 1'b0;
   logic rst  = 1'b1;
   int   cyc  = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t q[$];

   alarm_bank_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

   alarm_bank #(
      .N_CH       (N_CH),
      .CH_W       (CH_W),
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .BLINK_DIV  (BLINK_DIV)
   ) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   // Monitor: pops every expectation tagged with the current cycle.
   always @(negedge mclk) begin : mon
      exp_t e;
      logic ok;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e  = q.pop_front();
         ok = (e.cyc == cyc) && (bus.armed == e.armed) && (bus.ring == e.ring)
              && (bus.any_ring == (|e.ring)) && (bus.wr_err == e.err)
              && (!e.led_chk || bus.alarm_led == e.led);
         n_chk++;
         if (ok) n_pass++;
         else $display("FAIL %s: got armed=%b ring=%b any=%b err=%b led=%b, want armed=%b ring=%b any=%b err=%b led=%b(chk=%b)",
                       e.name, bus.armed, bus.ring, bus.any_ring, bus.wr_err, bus.alarm_led,
                       e.armed, e.ring, |e.ring, e.err, e.led, e.led_chk);
      end
   end

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [N_CH-1:0] a, input logic [N_CH-1:0] r,
                      input logic err, input logic lc, input logic l);
      exp_t e;
      e.cyc = cyc; e.name = name; e.armed = a; e.ring = r;
      e.err = err; e.led_chk = lc; e.led = l;
      q.push_back(e);
   endtask

   task automatic tick_at(input int h, input int m, input int s);
      bus.cur_hour = 5'(h);
      bus.cur_min  = 6'(m);
      bus.cur_sec  = 6'(s);
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
   endtask

   task automatic wr(input int ch, input int h, input int m, input logic arm);
      bus.wr_en   = 1'b1;
      bus.wr_ch   = CH_W'(ch);
      bus.wr_hour = 5'(h);
      bus.wr_min  = 6'(m);
      bus.wr_arm  = arm;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic pulse_snooze();
      bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
   endtask

   initial begin
      bus.tick_1hz = 0; bus.cur_hour = 0; bus.cur_min = 0; bus.cur_sec = 0;
      bus.wr_en = 0; bus.wr_ch = 0; bus.wr_hour = 0; bus.wr_min = 0; bus.wr_arm = 0;
      bus.ack = 0; bus.snooze = 0;
      step(); step();
      chk("reset", 3'b000, 3'b000, 0, 1, 0);
      rst = 1'b0;
      step();

      // Single channel ring and timeout
      wr(1, 7, 30, 1);      chk("t1_write",   3'b010, 3'b000, 0, 1, 0);
      tick_at(7, 29, 59);   chk("t1_nomatch", 3'b010, 3'b000, 0, 0, 0);
      tick_at(7, 30, 0);    chk("t1_ring",    3'b010, 3'b010, 0, 1, 1);
      tick_at(7, 30, 1);
      tick_at(7, 30, 2);    chk("t1_ringing", 3'b010, 3'b010, 0, 0, 0);
      tick_at(7, 30, 3);    chk("t1_timeout", 3'b010, 3'b000, 0, 1, 0);

      // Blink cadence, snooze and ack
      wr(0, 6, 0, 1);       chk("t2_write",   3'b011, 3'b000, 0, 0, 0);
      tick_at(6, 0, 0);     chk("t2_ring",    3'b011, 3'b001, 0, 1, 1);
      repeat (3) step();    chk("blink_c3",   3'b011, 3'b001, 0, 1, 1);
      step();               chk("blink_c4",   3'b011, 3'b001, 0, 1, 0);
      repeat (3) step();    chk("blink_c7",   3'b011, 3'b001, 0, 1, 0);
      step();               chk("blink_c8",   3'b011, 3'b001, 0, 1, 1);
      pulse_snooze();       chk("t2_snooze",  3'b011, 3'b000, 0, 1, 0);
      tick_at(6, 0, 10);    chk("t2_snz1",    3'b011, 3'b000, 0, 0, 0);
      tick_at(6, 0, 11);    chk("t2_resume",  3'b011, 3'b001, 0, 1, 1);
      pulse_ack();          chk("t2_ack",     3'b011, 3'b000, 0, 1, 0);

      // Invalid writes
      wr(2, 24, 0, 1);      chk("t3_hour",    3'b011, 3'b000, 1, 0, 0);
      step();               chk("t3_errclr",  3'b011, 3'b000, 0, 0, 0);
      wr(2, 10, 60, 1);     chk("t3_min",     3'b011, 3'b000, 1, 0, 0);
      wr(3, 10, 0, 1);      chk("t3_ch",      3'b011, 3'b000, 1, 0, 0);
      wr(2, 23, 59, 0);     chk("t3_edge_ok", 3'b011, 3'b000, 0, 0, 0);

      // Two channels together
      wr(0, 12, 0, 1);
      wr(2, 12, 0, 1);      chk("t4_write",   3'b111, 3'b000, 0, 0, 0);
      tick_at(12, 0, 0);    chk("t4_both",    3'b111, 3'b101, 0, 1, 1);
      pulse_snooze();       chk("t4_snooze",  3'b111, 3'b000, 0, 0, 0);
      tick_at(12, 0, 5);    chk("t4_snz1",    3'b111, 3'b000, 0, 0, 0);
      pulse_ack();          chk("t4_ack",     3'b111, 3'b000, 0, 0, 0);
      tick_at(12, 0, 6);
      tick_at(12, 0, 7);    chk("t4_stay",    3'b111, 3'b000, 0, 1, 0);

      // Write beats ack on the same cycle
      tick_at(12, 0, 0);    chk("t5_ring",    3'b111, 3'b101, 0, 0, 0);
      bus.wr_en = 1; bus.wr_ch = 2'd0; bus.wr_hour = 5'd12; bus.wr_min = 6'd0; bus.wr_arm = 0;
      bus.ack = 1;
      step();
      bus.wr_en = 0; bus.ack = 0;
      chk("t5_wr_ack", 3'b110, 3'b000, 0, 1, 0);

      // Reset mid-ring, ticks during reset ignored
      tick_at(12, 0, 0);    chk("t6_ring",    3'b110, 3'b100, 0, 1, 1);
      step(); step();
      rst = 1'b1;
      bus.cur_hour = 5'd7; bus.cur_min = 6'd30; bus.cur_sec = 6'd0; bus.tick_1hz = 1'b1;
      step();               chk("t6_reset",   3'b000, 3'b000, 0, 1, 0);
      step();
      bus.tick_1hz = 1'b0;
      rst = 1'b0;
      step();               chk("t6_quiet",   3'b000, 3'b000, 0, 1, 0);
      tick_at(12, 0, 0);    chk("t6_no12",    3'b000, 3'b000, 0, 0, 0);
      tick_at(7, 30, 0);    chk("t6_no730",   3'b000, 3'b000, 0, 0, 0);

      // Write and match on the same cycle: new time takes effect
      wr(1, 7, 30, 1);      chk("t7_arm",     3'b010, 3'b000, 0, 0, 0);
      bus.wr_en = 1; bus.wr_ch = 2'd1; bus.wr_hour = 5'd9; bus.wr_min = 6'd0; bus.wr_arm = 1;
      bus.cur_hour = 5'd7; bus.cur_min = 6'd30; bus.cur_sec = 6'd0; bus.tick_1hz = 1;
      step();
      bus.wr_en = 0; bus.tick_1hz = 0;
      chk("t7_wr_wins", 3'b010, 3'b000, 0, 0, 0);
      tick_at(9, 0, 0);     chk("t7_newtime", 3'b010, 3'b010, 0, 1, 1);

      for (int i = 0; i < 20 && q.size() > 0; i++) step();
      if (q.size() > 0) begin
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
         n_chk += q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
